// File: rtl/tlb_miss_sched_pkg.sv
// tlb_miss_sched_pkg: shared types, defaults and helpers for the TLB miss handler scheduler.
package tlb_miss_sched_pkg;
    typedef enum logic [1:0] {Idle, Wake, Handling} state_e;
    localparam int DefNumCores = 8;
    localparam int DefTimeoutWidth = 16;
    localparam int DefErrCntWidth = 8;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tlb_miss_handler_sched_if.sv
// tlb_miss_handler_sched_if: miss-queue and per-core handshake bundle of the handler scheduler.
interface tlb_miss_handler_sched_if
    import tlb_miss_sched_pkg::*;
#(
    parameter int NumCores = DefNumCores,
    parameter int ErrCntWidth = DefErrCntWidth
);
    logic                             miss_pending;
    logic [NumCores-1:0]              avail;
    logic [NumCores-1:0]              claim;
    logic [NumCores-1:0]              done;
    logic [NumCores-1:0]              wake;
    logic                             handler_valid;
    logic [idx_width(NumCores)-1:0]   handler_idx;
    logic                             timeout;
    logic [ErrCntWidth-1:0]           err_cnt;
    modport master (input miss_pending, avail, claim, done,
                    output wake, handler_valid, handler_idx, timeout, err_cnt);
    modport slave  (output miss_pending, avail, claim, done,
                    input wake, handler_valid, handler_idx, timeout, err_cnt);
endinterface

// File: rtl/tlb_sched_rr_pick.sv
// tlb_sched_rr_pick: cyclic first-one picker; lowest set bit of mask at or after start, wrapping.
module tlb_sched_rr_pick
    import tlb_miss_sched_pkg::*;
#(
    parameter int N = DefNumCores,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    // rotating a doubled copy lets a plain trailing-one scan handle the wrap
    always_comb begin
        rot = N'({mask, mask} >> start);
        off = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
        sum = {1'b0, start} + {1'b0, off};
        idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    end
    assign valid = |mask;
endmodule

// File: rtl/tlb_miss_handler_sched.sv
// tlb_miss_handler_sched: round-robin wake of a handler core for the shared TLB miss queue,
// with claim timeout, per-core exclusion and a saturating timeout counter.
module tlb_miss_handler_sched
    import tlb_miss_sched_pkg::*;
#(
    parameter int NumCores = DefNumCores,
    parameter int TimeoutWidth = DefTimeoutWidth,
    parameter int ErrCntWidth = DefErrCntWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [TimeoutWidth-1:0] timeout_cfg_i,
    tlb_miss_handler_sched_if.master bus
);
    localparam int IW = idx_width(NumCores);
    localparam logic [NumCores-1:0] One = NumCores'(1);

    state_e                  state_q, state_n;
    logic [IW-1:0]           sel_q, sel_n, rr_q, rr_n, pick_idx, sel_inc;
    logic [NumCores-1:0]     excl_q, excl_n, elig;
    logic [TimeoutWidth-1:0] cnt_q, cnt_n, cnt_inc;
    logic [ErrCntWidth-1:0]  err_q, err_n;
    logic                    tmo_q, tmo_n, pick_vld, tmo_hit;

    assign elig    = bus.avail & ~excl_q;
    assign sel_inc = (sel_q == IW'(NumCores - 1)) ? '0 : sel_q + 1'b1;
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = (timeout_cfg_i != '0) && (cnt_inc == timeout_cfg_i);

    tlb_sched_rr_pick #(.N(NumCores)) u_pick (
        .mask  (elig),
        .start (rr_q),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        rr_n    = rr_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        tmo_n   = 1'b0;
        // every available core already skipped: forget the exclusions and retry all
        excl_n  = (~|elig && |(bus.avail & excl_q)) ? '0 : excl_q;
        case (state_q)
            Idle: if (enable_i && bus.miss_pending && pick_vld) begin
                sel_n   = pick_idx;
                cnt_n   = '0;
                state_n = Wake;
            end
            Wake: begin
                cnt_n = cnt_inc;
                if (bus.claim[sel_q]) begin
                    excl_n[sel_q] = 1'b0;
                    state_n       = Handling;
                end else if (tmo_hit) begin
                    tmo_n         = 1'b1;
                    excl_n[sel_q] = 1'b1;
                    err_n         = (&err_q) ? err_q : err_q + 1'b1;
                    rr_n          = sel_inc;
                    state_n       = Idle;
                end else if (!bus.avail[sel_q] || !enable_i) state_n = Idle;
            end
            Handling: if (bus.done[sel_q]) begin
                rr_n    = sel_inc;
                state_n = Idle;
            end
            default: state_n = Idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            sel_q   <= '0;
            rr_q    <= '0;
            excl_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            rr_q    <= rr_n;
            excl_q  <= excl_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            tmo_q   <= tmo_n;
        end
    end

    assign bus.wake          = (state_q == Wake) ? One << sel_q : '0;
    assign bus.handler_valid = state_q != Idle;
    assign bus.handler_idx   = sel_q;
    assign bus.timeout       = tmo_q;
    assign bus.err_cnt       = err_q;
endmodule
